// File: rtl/mod_up_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// up_down_counter_pkg
// Shared types and helpers for the modulus up/down counter.
//   mode_e      : boundary behaviour, MODE_WRAP (0) or MODE_SAT (1)
//   clamp_load  : limits a load value to the programmed modulus
// -----------------------------------------------------------------------------
package up_down_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Functions in a package cannot take a width parameter, so the helper
  // works at a fixed generous width; callers zero-extend their operands
  // and cast the result back to their own width.
  localparam int unsigned CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp_load(
    input logic [CLAMP_W-1:0] d,
    input logic [CLAMP_W-1:0] modulus
  );
    return (d > modulus) ? modulus : d;
  endfunction

endpackage

// File: rtl/mod_up_down_counter_step_unit.sv
// -----------------------------------------------------------------------------
// mod_step_unit
// Purely combinational next-count calculation for the modulus counter.
// Ports:
//   q            in  current count
//   step         in  raw increment/decrement amount
//   modulus      in  maximum legal count (range 0..modulus)
//   up_down      in  1 = count up, 0 = count down
//   mode         in  mode_e encoding (wrap / saturate)
//   next_q       out value the counter takes if a count happens this edge
//   boundary     out the count crosses (or starts outside) the legal range
//   dir_up       out direction of the count (for flag attribution)
//   out_of_range out current q is above modulus (modulus was lowered)
//   step_nz      out effective step is non-zero, i.e. a count can happen
// -----------------------------------------------------------------------------
module mod_step_unit
  import up_down_counter_pkg::*;
#(
  parameter int NBITS     = 8,
  parameter int STEP_BITS = 4
) (
  input  logic [NBITS-1:0]     q,
  input  logic [STEP_BITS-1:0] step,
  input  logic [NBITS-1:0]     modulus,
  input  logic                 up_down,
  input  logic                 mode,
  output logic [NBITS-1:0]     next_q,
  output logic                 boundary,
  output logic                 dir_up,
  output logic                 out_of_range,
  output logic                 step_nz
);

  // One extra bit so that modulus+1 and q+step never truncate.
  localparam int W  = NBITS + 1;
  // Comparison width for clamping the step; the step may be wider than W.
  localparam int SW = (STEP_BITS > W) ? STEP_BITS : W;

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  logic [W-1:0]  q_x;
  logic [W-1:0]  mod_x;
  logic [W-1:0]  span_x;      // modulus + 1: number of legal states
  logic [SW-1:0] step_w;
  logic [SW-1:0] span_w;
  logic [W-1:0]  step_eff;
  logic [W-1:0]  sum_x;
  logic [W-1:0]  wrap_up_x;
  logic [W-1:0]  wrap_dn_x;

  assign q_x    = {1'b0, q};
  assign mod_x  = {1'b0, modulus};
  assign span_x = mod_x + W'(1);

  // A step larger than the whole range is pointless; clamping it keeps the
  // wrap arithmetic below inside a single turn of the range.
  assign step_w   = SW'(step);
  assign span_w   = SW'(span_x);
  assign step_eff = (step_w > span_w) ? span_x : W'(step_w);

  // With q <= modulus and step_eff <= modulus+1 none of these overflow W bits.
  assign sum_x     = q_x + step_eff;
  assign wrap_up_x = sum_x - span_x;
  assign wrap_dn_x = q_x + span_x - step_eff;

  assign out_of_range = (q_x > mod_x);
  assign step_nz      = (step_eff != '0);
  assign dir_up       = up_down;

  always_comb begin
    next_q   = q;
    boundary = 1'b0;
    if (up_down) begin
      if (out_of_range) begin
        // Stale count above a freshly lowered modulus: treat as overflow.
        boundary = 1'b1;
        next_q   = (mode_sel == MODE_SAT) ? modulus : '0;
      end else if (sum_x <= mod_x) begin
        next_q = NBITS'(sum_x);
      end else begin
        boundary = 1'b1;
        next_q   = (mode_sel == MODE_SAT) ? modulus : NBITS'(wrap_up_x);
      end
    end else begin
      if (out_of_range) begin
        // Pull the stale count back to the top of the range.
        boundary = 1'b1;
        next_q   = modulus;
      end else if (q_x >= step_eff) begin
        next_q = NBITS'(q_x - step_eff);
      end else begin
        boundary = 1'b1;
        next_q   = (mode_sel == MODE_SAT) ? '0 : NBITS'(wrap_dn_x);
      end
    end
  end

endmodule

// File: rtl/mod_up_down_counter.sv
// -----------------------------------------------------------------------------
// mod_up_down_counter
// Up/down counter with programmable modulus and step, wrap or saturate mode,
// load clamping, registered terminal-count pulse and sticky over/underflow.
// Ports:
//   clk        in  clock, all state updates on the rising edge
//   reset      in  synchronous active-high reset
//   en         in  count enable
//   load       in  load d (clamped to modulus)
//   up_down    in  1 = up, 0 = down
//   mode       in  0 = wrap, 1 = saturate
//   d          in  load value
//   step       in  increment/decrement amount
//   modulus    in  maximum count
//   clr_flags  in  clear sticky ovf/unf (a same-edge set wins)
//   q / qn     out count and its bitwise inverse
//   tc         out one cycle per boundary event, aligned with the new q
//   ovf / unf  out sticky overflow / underflow flags
// Priority each edge: reset > load > count (en and non-zero step) > hold.
// -----------------------------------------------------------------------------
module mod_up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int NBITS     = 8,
  parameter int STEP_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 load,
  input  logic                 up_down,
  input  logic                 mode,
  input  logic [NBITS-1:0]     d,
  input  logic [STEP_BITS-1:0] step,
  input  logic [NBITS-1:0]     modulus,
  input  logic                 clr_flags,
  output logic [NBITS-1:0]     q,
  output logic [NBITS-1:0]     qn,
  output logic                 tc,
  output logic                 ovf,
  output logic                 unf
);

  logic [NBITS-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [NBITS-1:0] step_next;
  logic             step_boundary;
  logic             step_dir_up;
  logic             step_oor;
  logic             step_nz;
  logic [NBITS-1:0] load_val;
  logic             count_fire;

  mod_step_unit #(
    .NBITS     (NBITS),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .q            (q_q),
    .step         (step),
    .modulus      (modulus),
    .up_down      (up_down),
    .mode         (mode),
    .next_q       (step_next),
    .boundary     (step_boundary),
    .dir_up       (step_dir_up),
    .out_of_range (step_oor),
    .step_nz      (step_nz)
  );

  assign load_val   = NBITS'(clamp_load(CLAMP_W'(d), CLAMP_W'(modulus)));
  assign count_fire = en && step_nz;

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    // Clear first so that an event on the same edge re-sets the flag.
    ovf_d = ovf_q & ~clr_flags;
    unf_d = unf_q & ~clr_flags;
    if (load) begin
      q_d = load_val;
    end else if (count_fire) begin
      q_d  = step_next;
      tc_d = step_boundary;
      if (step_boundary && step_dir_up) begin
        ovf_d = 1'b1;
      end
      // Recovering from a lowered modulus is not a real underflow.
      if (step_boundary && !step_dir_up && !step_oor) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign q   = q_q;
  assign qn  = ~q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_mod_up_down_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_up_down_counter
// Directed vector table, hand-written reset sequences, then randomized
// stimulus compared against an integer reference model of the counter rules.
// -----------------------------------------------------------------------------
module tb_mod_up_down_counter;

  localparam int NB = 4;
  localparam int SB = 4;

  logic          clk;
  logic          reset, en, load, up_down, mode, clr_flags;
  logic [NB-1:0] d, modulus, q, qn;
  logic [SB-1:0] step;
  logic          tc, ovf, unf;

  int checks = 0;
  int errors = 0;

  mod_up_down_counter #(.NBITS(NB), .STEP_BITS(SB)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .up_down   (up_down),
    .mode      (mode),
    .d         (d),
    .step      (step),
    .modulus   (modulus),
    .clr_flags (clr_flags),
    .q         (q),
    .qn        (qn),
    .tc        (tc),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic          rst, en, ld, ud, md;
    logic [NB-1:0] d;
    logic [SB-1:0] step;
    logic [NB-1:0] modv;
    logic          clr;
    logic [NB-1:0] eq;
    logic          etc, eovf, eunf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_v, en_v, ld_v, ud_v, md_v,
                              input int d_v, step_v, mod_v,
                              input logic clr_v,
                              input int eq_v, input logic etc_v, eovf_v, eunf_v);
    vec_t v;
    v.rst = rst_v; v.en = en_v; v.ld = ld_v; v.ud = ud_v; v.md = md_v;
    v.d = NB'(d_v); v.step = SB'(step_v); v.modv = NB'(mod_v); v.clr = clr_v;
    v.eq = NB'(eq_v); v.etc = etc_v; v.eovf = eovf_v; v.eunf = eunf_v;
    return v;
  endfunction

  task automatic drive(input logic rst_v, en_v, ld_v, ud_v, md_v,
                       input logic [NB-1:0] d_v, input logic [SB-1:0] step_v,
                       input logic [NB-1:0] mod_v, input logic clr_v);
    reset = rst_v; en = en_v; load = ld_v; up_down = ud_v; mode = md_v;
    d = d_v; step = step_v; modulus = mod_v; clr_flags = clr_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [NB-1:0] eq,
                       input logic etc, eovf, eunf);
    logic [NB-1:0] eqn;
    eqn = ~eq;
    checks++;
    if (q !== eq) begin
      errors++;
      $display("FAIL %s q: got %0d expected %0d", nm, q, eq);
    end
    checks++;
    if (qn !== eqn) begin
      errors++;
      $display("FAIL %s qn: got %h expected %h", nm, qn, eqn);
    end
    checks++;
    if (tc !== etc) begin
      errors++;
      $display("FAIL %s tc: got %b expected %b", nm, tc, etc);
    end
    checks++;
    if (ovf !== eovf) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", nm, ovf, eovf);
    end
    checks++;
    if (unf !== eunf) begin
      errors++;
      $display("FAIL %s unf: got %b expected %b", nm, unf, eunf);
    end
    $display("%s: q=%0d qn=%h tc=%b ovf=%b unf=%b", nm, q, qn, tc, ovf, unf);
  endtask

  // Reference model: plain integer arithmetic on the counter rules.
  int mq, mtc, movf, munf;

  task automatic model_step();
    int m, se, s, nov, nun;
    if (reset) begin
      mq = 0; mtc = 0; movf = 0; munf = 0;
      return;
    end
    m   = int'(modulus);
    se  = (int'(step) > m + 1) ? m + 1 : int'(step);
    mtc = 0;
    nov = (movf != 0 && !clr_flags) ? 1 : 0;
    nun = (munf != 0 && !clr_flags) ? 1 : 0;
    if (load) begin
      mq = (int'(d) > m) ? m : int'(d);
    end else if (en && se > 0) begin
      if (up_down) begin
        if (mq > m) begin
          mq = mode ? m : 0; nov = 1; mtc = 1;
        end else begin
          s = mq + se;
          if (s <= m) mq = s;
          else begin
            mq = mode ? m : s - (m + 1); nov = 1; mtc = 1;
          end
        end
      end else begin
        if (mq > m) begin
          mq = m; mtc = 1;
        end else if (mq >= se) begin
          mq = mq - se;
        end else begin
          mq = mode ? 0 : mq + (m + 1) - se; nun = 1; mtc = 1;
        end
      end
    end
    movf = nov;
    munf = nun;
  endtask

  initial begin
    drive(1, 0, 0, 1, 0, 0, 0, 9, 0);

    //           rst en ld ud md  d  st mod clr  q  tc ov un
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 9, 0,   0, 0, 0, 0)); // reset
    tbl.push_back(mk(0, 0, 1, 1, 0, 8, 0, 9, 0,   8, 0, 0, 0)); // load 8
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 3, 9, 0,   1, 1, 1, 0)); // up wrap 8+3
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 3, 9, 0,   4, 0, 1, 0)); // tc drops
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 3, 9, 1,   4, 0, 0, 0)); // clr flags
    tbl.push_back(mk(0, 0, 1, 1, 0, 2, 0, 9, 0,   2, 0, 0, 0)); // load 2
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 3, 9, 0,   0, 1, 0, 1)); // down sat
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 3, 9, 0,   0, 1, 0, 1)); // sat at 0 again
    tbl.push_back(mk(0, 1, 1, 1, 0, 12, 1, 9, 0,  9, 0, 0, 1)); // load clamp
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 9, 1,   0, 1, 1, 0)); // set beats clr
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 9, 1,   0, 0, 0, 0)); // clr alone
    tbl.push_back(mk(0, 0, 1, 1, 1, 7, 0, 9, 0,   7, 0, 0, 0)); // load 7
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 9, 0,   7, 0, 0, 0)); // en=0
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 9, 0,   7, 0, 0, 0)); // en=0
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 9, 0,   7, 0, 0, 0)); // step=0
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 9, 0,   7, 0, 0, 0)); // step=0
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 9, 0,   7, 0, 0, 0)); // step=0
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1, 4, 0,   4, 1, 1, 0)); // lowered mod, sat
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 15, 9, 0,  4, 1, 1, 1)); // step clamped to 10
    tbl.push_back(mk(0, 0, 1, 1, 0, 9, 0, 9, 1,   9, 0, 0, 0)); // load 9, clr
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 0,   3, 1, 0, 0)); // out of range down
    tbl.push_back(mk(0, 0, 1, 1, 0, 9, 0, 9, 0,   9, 0, 0, 0)); // load 9
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 2, 5, 0,   0, 1, 1, 0)); // out of range up wrap
    tbl.push_back(mk(0, 0, 1, 1, 0, 5, 0, 0, 1,   0, 0, 0, 0)); // mod 0 load
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 2, 0, 0,   0, 1, 1, 0)); // mod 0 up
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 2, 0, 0,   0, 1, 1, 1)); // mod 0 down
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 5, 15, 0,  5, 0, 1, 1)); // plain up

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].ud, tbl[i].md,
            tbl[i].d, tbl[i].step, tbl[i].modv, tbl[i].clr);
      tick();
      check($sformatf("vec%0d", i), tbl[i].eq, tbl[i].etc, tbl[i].eovf, tbl[i].eunf);
    end

    // Reset pulse entirely between edges must be ignored.
    drive(1, 0, 0, 1, 0, 0, 0, 9, 0);
    tick();
    drive(0, 0, 1, 1, 0, 9, 0, 9, 0);
    tick();
    drive(0, 1, 0, 1, 0, 0, 1, 9, 0);
    tick();
    check("seq_ovf", 0, 1, 1, 0);
    drive(0, 0, 1, 1, 0, 5, 0, 9, 0);
    tick();
    check("seq_load5", 5, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 4, 9, 0);
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    tick();
    check("seq_rst_glitch", 5, 0, 1, 0);
    // Reset held across an edge while counting aborts the count.
    drive(1, 1, 0, 1, 0, 0, 4, 9, 0);
    tick();
    check("seq_rst_held", 0, 0, 0, 0);

    // Randomized phase against the reference model.
    mq = 0; mtc = 0; movf = 0; munf = 0;
    modulus = 4'd9;
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 49) == 0);
      load      = ($urandom_range(0, 9) == 0);
      en        = ($urandom_range(0, 3) != 0);
      up_down   = 1'($urandom);
      mode      = 1'($urandom);
      d         = NB'($urandom);
      step      = ($urandom_range(0, 3) == 0) ? SB'($urandom) : SB'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) modulus = NB'($urandom);
      clr_flags = ($urandom_range(0, 7) == 0);
      model_step();
      tick();
      check($sformatf("rnd%0d", n), NB'(mq), mtc[0], movf[0], munf[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
